// File: rtl/arb_pkg.sv
// Shared types for the three-way data-memory port arbiter.
// Holds FSM states, requester id type and the round-robin step helper.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam int         NREQ     = 3;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    typedef logic [1:0] req_id_t;

    // Next requester id in round-robin order, wrapping 2 -> 0.
    function automatic req_id_t rr_next(input req_id_t id);
        if (id == req_id_t'(NREQ - 1)) begin
            return req_id_t'(0);
        end
        return req_id_t'(id + 2'd1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker over three requesters.
// Ports: req (per-requester level), ptr (highest-priority id);
//        valid (any request), id (winner, searched ptr upward mod 3).
module rr_pick
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  req_id_t         ptr,
    output logic            valid,
    output req_id_t         id
);

    req_id_t c0;
    req_id_t c1;
    req_id_t c2;

    always_comb begin
        c0    = ptr;
        c1    = rr_next(c0);
        c2    = rr_next(c1);
        valid = |req;
        id    = '0;
        if (req[c0]) begin
            id = c0;
        end else if (req[c1]) begin
            id = c1;
        end else if (req[c2]) begin
            id = c2;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between fetch (0), load/store (1)
// and video/DMA (2), one access at a time, over a fixed memory latency.
// Ports: clk, rst (sync, active-high); req/we/addr/wdata per requester;
//        gnt (owner during ACCESS), done (1-cycle completion pulse),
//        rdata (registered read data), sel (mux select, 11 = idle),
//        mem_addr/mem_wdata/mem_we/mem_rdata to the RAM, busy.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 24,
    parameter int MEM_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*DATA_W-1:0] wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [DATA_W-1:0]      rdata,
    output logic [1:0]             sel,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic                   mem_we,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   busy
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    state_t           state;
    state_t           state_nx;
    req_id_t          ptr;
    req_id_t          owner;
    logic             owner_we;
    logic [CNT_W-1:0] cnt;
    logic             pick_valid;
    req_id_t          pick_id;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .id    (pick_id)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (pick_valid) state_nx = ACCESS;
            ACCESS:  if (cnt == '0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A reset mid-access simply drops the owner; no done is produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            owner_we <= 1'b0;
            cnt      <= '0;
            rdata    <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner    <= pick_id;
                        owner_we <= we[pick_id];
                        cnt      <= CNT_INIT;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!owner_we) begin
                        rdata <= mem_rdata;
                    end
                end
                RESP: begin
                    ptr <= rr_next(owner);
                end
                default: ;
            endcase
        end
    end

    // The RAM-side mux is driven straight from owner so the address
    // tracks the owner's live inputs throughout ACCESS.
    always_comb begin
        gnt       = '0;
        done      = '0;
        sel       = SEL_IDLE;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        unique case (state)
            ACCESS: begin
                gnt[owner] = 1'b1;
                sel        = owner;
                mem_addr   = addr[int'(owner)*ADDR_W +: ADDR_W];
                mem_wdata  = wdata[int'(owner)*DATA_W +: DATA_W];
                // cnt still holds its load value only on the first cycle.
                mem_we     = owner_we && (cnt == CNT_INIT);
                busy       = 1'b1;
            end
            RESP: begin
                done[owner] = 1'b1;
                busy        = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
